jtag_tap_controller: RTL and testbench



---
 rtl/jtag_tap_controller.sv | 191 +++++++++++++++++++
 tb/tb_jtag_tap_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller.sv
// ---------------------------------------------------------------------------
// jtag_tap_controller
//
// IEEE 1149.1 TAP controller for the debug transport module. It owns the
// 16-state TAP FSM, the instruction register and the TDO mux. It drives the
// capture/shift/update strobes of the downstream DR chains. Those strobes are
// decoded from the state register, so at most one of them is high at a time.
//
// Parameters:
//   IR_WIDTH      instruction register width in bits (2..32)
//   IDCODE_INSTR  instruction loaded on reset and while in Test-Logic-Reset
//
// Ports:
//   clock                in   TCK-domain clock, rising-edge active
//   reset                in   asynchronous, active-high reset
//   io_tms               in   test mode select
//   io_tdi               in   test data in
//   io_chainIn_data      in   serial output (LSB) of the selected DR chain
//   io_tdo               out  test data out
//   io_tdo_en            out  high in Shift-DR or Shift-IR
//   io_chainOut_capture  out  high in Capture-DR
//   io_chainOut_shift    out  high in Shift-DR
//   io_chainOut_update   out  high in Update-DR
//   io_instruction       out  active instruction [IR_WIDTH-1:0]
//   io_state             out  current TAP state encoding [3:0]
//
// Optional build macro:
//   JTAG_TAP_ASSERT_EN   adds simulation-only protocol assertions. Functional
//                        outputs are the same whether or not it is defined.
// ---------------------------------------------------------------------------
module jtag_tap_controller #(
    parameter int unsigned IR_WIDTH     = 5,
    parameter int unsigned IDCODE_INSTR = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_tms,
    input  logic                io_tdi,
    input  logic                io_chainIn_data,
    output logic                io_tdo,
    output logic                io_tdo_en,
    output logic                io_chainOut_capture,
    output logic                io_chainOut_shift,
    output logic                io_chainOut_update,
    output logic [IR_WIDTH-1:0] io_instruction,
    output logic [3:0]          io_state
);

    // Standard 1149.1 state encodings.
    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IDCODE     = IR_WIDTH'(IDCODE_INSTR);
    // The IR capture pattern has the two LSBs fixed at 2'b01.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e          state_q;
    tap_state_e          state_d;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] instr_q;

    // ------------------------------------------------------------------
    // State register, IR shift register and instruction register
    // ------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments. Every flop then samples
    // the values from before the edge, so the order of statements here does
    // not matter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TLR;
            ir_sr   <= '0;
            instr_q <= IDCODE;
        end else begin
            state_q <= state_d;

            case (state_q)
                CAP_IR:  ir_sr <= IR_CAPTURE;
                // Shift toward the LSB. ir_sr[0] is on TDO during this state.
                SH_IR:   ir_sr <= {io_tdi, ir_sr[IR_WIDTH-1:1]};
                default: ir_sr <= ir_sr;
            endcase

            if (state_q == TLR) begin
                instr_q <= IDCODE;
            end else if (state_q == UPD_IR) begin
                instr_q <= ir_sr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and state decodes
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_d             = state_q;
        io_chainOut_capture = 1'b0;
        io_chainOut_shift   = 1'b0;
        io_chainOut_update  = 1'b0;
        io_tdo_en           = 1'b0;
        io_tdo              = 1'b0;

        case (state_q)
            TLR:    state_d = io_tms ? TLR    : RTI;
            RTI:    state_d = io_tms ? SEL_DR : RTI;
            SEL_DR: state_d = io_tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = io_tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = io_tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = io_tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = io_tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = io_tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = io_tms ? SEL_DR : RTI;
            SEL_IR: state_d = io_tms ? TLR    : CAP_IR;
            CAP_IR: state_d = io_tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = io_tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = io_tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = io_tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = io_tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = io_tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase

        // Each strobe decodes a single state, so the strobes are one-hot or all zero.
        case (state_q)
            CAP_DR: io_chainOut_capture = 1'b1;
            SH_DR: begin
                io_chainOut_shift = 1'b1;
                io_tdo_en         = 1'b1;
                io_tdo            = io_chainIn_data;
            end
            UPD_DR: io_chainOut_update = 1'b1;
            SH_IR: begin
                io_tdo_en = 1'b1;
                io_tdo    = ir_sr[0];
            end
            default: ;
        endcase

        // IDCODE drives the output combinationally in TLR. This covers the
        // first TLR cycle before instr_q has reloaded.
        io_instruction = (state_q == TLR) ? IDCODE : instr_q;
    end

    assign io_state = state_q;

`ifdef JTAG_TAP_ASSERT_EN
`ifndef SYNTHESIS
    // Counts consecutive tms=1 edges and saturates at 5.
    logic [2:0] tms_ones;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tms_ones <= '0;
        end else if (!io_tms) begin
            tms_ones <= '0;
        end else if (tms_ones != 3'd5) begin
            tms_ones <= tms_ones + 3'd1;
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert ($countones({io_chainOut_capture, io_chainOut_shift, io_chainOut_update}) <= 1)
            else $display("jtag_tap_controller: chain strobes overlap in state %h", state_q);
            assert (io_tdo_en == ((state_q == SH_IR) || (state_q == SH_DR)))
            else $display("jtag_tap_controller: tdo_en wrong in state %h", state_q);
            assert ((tms_ones != 3'd5) || (state_q == TLR))
            else $display("jtag_tap_controller: five tms=1 did not reach TLR (state %h)", state_q);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_jtag_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_controller
//
// Directed bench for jtag_tap_controller with IR_WIDTH=5 and IDCODE_INSTR=1.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a period away from the rising edge where the DUT acts.
// ---------------------------------------------------------------------------
module tb_jtag_tap_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_tms;
    logic       io_tdi;
    logic       io_chainIn_data;
    logic       io_tdo;
    logic       io_tdo_en;
    logic       io_chainOut_capture;
    logic       io_chainOut_shift;
    logic       io_chainOut_update;
    logic [4:0] io_instruction;
    logic [3:0] io_state;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_tap_controller #(
        .IR_WIDTH     (5),
        .IDCODE_INSTR (1)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .io_tms              (io_tms),
        .io_tdi              (io_tdi),
        .io_chainIn_data     (io_chainIn_data),
        .io_tdo              (io_tdo),
        .io_tdo_en           (io_tdo_en),
        .io_chainOut_capture (io_chainOut_capture),
        .io_chainOut_shift   (io_chainOut_shift),
        .io_chainOut_update  (io_chainOut_update),
        .io_instruction      (io_instruction),
        .io_state            (io_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Applies tms/tdi, then waits one rising edge and returns on the falling edge.
    task automatic step(input logic tms, input logic tdi);
        io_tms = tms;
        io_tdi = tdi;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Checks the state and the decodes that follow from that state.
    task automatic chk_state(input string tag, input logic [3:0] exp_state);
        check({tag, ".state"},   {28'd0, io_state},            {28'd0, exp_state});
        check({tag, ".capture"}, {31'd0, io_chainOut_capture}, {31'd0, exp_state == 4'h6});
        check({tag, ".shift"},   {31'd0, io_chainOut_shift},   {31'd0, exp_state == 4'h2});
        check({tag, ".update"},  {31'd0, io_chainOut_update},  {31'd0, exp_state == 4'h5});
        check({tag, ".tdo_en"},  {31'd0, io_tdo_en},           {31'd0, (exp_state == 4'h2) || (exp_state == 4'hA)});
    endtask

    // From RTI: load a 5-bit instruction LSB first and return to RTI.
    task automatic load_ir(input logic [4:0] value);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(i == 4, value[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] dr_tms_exp [7];
        logic [4:0] tdi_bits;
        logic [4:0] tdo_bits;
        logic [3:0] pau_path [5];
        int         overlaps;
        int         tdo_en_bad;
        int         tdo_bad;
        int         five_bad;
        int         ones;

        reset           = 1'b1;
        io_tms          = 1'b0;
        io_tdi          = 1'b0;
        io_chainIn_data = 1'b0;

        // ---- Reset state ----
        @(negedge clock);
        chk_state("reset", 4'hF);
        check("reset.instr", {27'd0, io_instruction}, 32'h1);
        check("reset.tdo",   {31'd0, io_tdo},         32'h0);

        reset = 1'b0;
        step(1'b0, 1'b0);
        chk_state("rel_rti", 4'hC);

        // ---- DR scan: tms 1,0,0,0,1,1,0 -> 7,6,2,2,1,5,C ----
        dr_tms_exp = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h5, 4'hC};
        for (int i = 0; i < 7; i++) begin
            step((i == 0) || (i == 4) || (i == 5), 1'b0);
            chk_state($sformatf("dr%0d", i), dr_tms_exp[i]);
            // First Shift-DR cycle: TDO follows the chain combinationally.
            if (i == 2) begin
                io_chainIn_data = 1'b1; #1;
                check("shdr.tdo1", {31'd0, io_tdo}, 32'h1);
                io_chainIn_data = 1'b0; #1;
                check("shdr.tdo0", {31'd0, io_tdo}, 32'h0);
                io_chainIn_data = 1'b1; #1;
                check("shdr.tdo1b", {31'd0, io_tdo}, 32'h1);
                check("shdr.tdo_en", {31'd0, io_tdo_en}, 32'h1);
                @(negedge clock);
            end
        end
        io_chainIn_data = 1'b0;

        // ---- IR load of 5'h11: tdo emits capture pattern 1,0,0,0,0 ----
        step(1'b1, 1'b0); chk_state("ir_seldr", 4'h7);
        step(1'b1, 1'b0); chk_state("ir_selir", 4'h4);
        step(1'b0, 1'b0); chk_state("ir_cap",   4'hE);
        step(1'b0, 1'b0); chk_state("ir_sh",    4'hA);
        tdi_bits = 5'b10001;
        tdo_bits = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ir_tdo%0d", i), {31'd0, io_tdo}, {31'd0, tdo_bits[i]});
            step(i == 4, tdi_bits[i]);
        end
        chk_state("ir_ex1", 4'h9);
        step(1'b1, 1'b0);
        chk_state("ir_upd", 4'hD);
        check("ir_upd.instr", {27'd0, io_instruction}, 32'h1);
        step(1'b0, 1'b0);
        chk_state("ir_rti", 4'hC);
        check("ir_rti.instr", {27'd0, io_instruction}, 32'h11);

        // ---- From Shift-DR, five tms=1 -> TLR; instruction forced to IDCODE ----
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_state("dr5_sh", 4'h2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk_state("dr5_selir", 4'h4);
        check("dr5_selir.instr", {27'd0, io_instruction}, 32'h11);
        step(1'b1, 1'b0);
        chk_state("dr5_tlr", 4'hF);
        check("dr5_tlr.instr", {27'd0, io_instruction}, 32'h1);

        // ---- Asynchronous reset in the middle of Shift-DR ----
        step(1'b0, 1'b0);
        load_ir(5'h11);
        check("reload.instr", {27'd0, io_instruction}, 32'h11);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        io_chainIn_data = 1'b1;
        #1;
        chk_state("mid_sh", 4'h2);
        check("mid_sh.tdo", {31'd0, io_tdo}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk_state("mid_rst", 4'hF);
        check("mid_rst.instr", {27'd0, io_instruction}, 32'h1);
        check("mid_rst.tdo",   {31'd0, io_tdo},         32'h0);
        @(negedge clock);
        io_chainIn_data = 1'b0;
        reset = 1'b0;
        step(1'b0, 1'b0);
        chk_state("mid_rel", 4'hC);
        check("mid_rel.instr", {27'd0, io_instruction}, 32'h1);

        // ---- From Pause-IR with instruction 5'h11, five tms=1 -> TLR ----
        load_ir(5'h11);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk_state("pau", 4'hB);
        check("pau.instr", {27'd0, io_instruction}, 32'h11);
        pau_path = '{4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("pau_tms%0d", i), {28'd0, io_state}, {28'd0, pau_path[i]});
        end
        check("pau_tlr.instr", {27'd0, io_instruction}, 32'h1);

        // ---- Random tms/tdi: strobe exclusivity, TDO mux, five-ones rule ----
        overlaps   = 0;
        tdo_en_bad = 0;
        tdo_bad    = 0;
        five_bad   = 0;
        ones       = 0;
        for (int i = 0; i < 10000; i++) begin
            io_chainIn_data = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ones = io_tms ? ones + 1 : 0;
            if (32'(io_chainOut_capture) + 32'(io_chainOut_shift) + 32'(io_chainOut_update) > 1)
                overlaps++;
            if (io_tdo_en !== ((io_state == 4'hA) || (io_state == 4'h2)))
                tdo_en_bad++;
            if ((io_state == 4'h2) && (io_tdo !== io_chainIn_data))
                tdo_bad++;
            if ((io_state != 4'h2) && (io_state != 4'hA) && (io_tdo !== 1'b0))
                tdo_bad++;
            if ((ones >= 5) && (io_state !== 4'hF))
                five_bad++;
        end
        check("rand.overlaps",   32'(overlaps),   32'h0);
        check("rand.tdo_en_bad", 32'(tdo_en_bad), 32'h0);
        check("rand.tdo_bad",    32'(tdo_bad),    32'h0);
        check("rand.five_bad",   32'(five_bad),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
